iurt_up_arbiter: RTL and testbench

//  Shares one IURT upstream byte channel (data_up_valid/ready/data_up toward the IPDBG host) between CHANNELS requesters.

---
 rtl/iurt_up_arbiter.sv | 161 ++++++++++++++++
 tb/tb_iurt_up_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iurt_up_arbiter.sv
// iurt_up_arbiter
//   Shares one IURT upstream byte channel (toward the IPDBG JtagHub) between
//   CHANNELS requesters. Grants are round-robin, one burst of at most
//   MAX_BURST data bytes per grant. With IURT_ARB_TAG_EN defined, every burst
//   is prefixed by a tag byte {HDR_NIBBLE, grant_id} so the host can demux;
//   without it, bursts are forwarded untagged.
//
//   Configuration macro: IURT_ARB_TAG_EN (tag byte per burst when defined).
//
//   Ports
//     clk            in   system clock
//     rst            in   synchronous reset, active high (wins over ce)
//     ce             in   clock enable; state advances only when ce=1
//     req_valid      in   [CHANNELS]    requester i has a byte
//     req_data       in   [8*CHANNELS]  byte of requester i at [8*i+:8]
//     req_ready      out  [CHANNELS]    byte of requester i accepted this cycle
//     data_up_ready  in   host side can take a byte
//     data_up_valid  out  registered output byte valid
//     data_up        out  [8]  registered output byte
//     grant_id       out  [4]  currently/last granted channel
module iurt_up_arbiter #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned MAX_BURST  = 8,
  parameter logic [3:0]  HDR_NIBBLE = 4'hA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [CHANNELS-1:0]   req_valid,
  input  logic [8*CHANNELS-1:0] req_data,
  output logic [CHANNELS-1:0]   req_ready,
  input  logic                  data_up_ready,
  output logic                  data_up_valid,
  output logic [7:0]            data_up,
  output logic [3:0]            grant_id
);

  typedef enum logic {S_IDLE, S_DATA} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);
  localparam logic [3:0] RR_INIT = 4'(CHANNELS - 1);

  state_t     r_state, w_state_nxt;
  logic       r_valid, w_valid_nxt;
  logic [7:0] r_data,  w_data_nxt;
  logic [3:0] r_grant, w_grant_nxt;
  logic [3:0] r_rr_ptr, w_rr_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;

  logic       w_slot_free;
  logic       w_sel_valid;
  logic [7:0] w_sel_data;
  logic       w_found;
  logic [3:0] w_win;

  // The output register can take a new byte when empty or being drained.
  assign w_slot_free = !r_valid || data_up_ready;

  // Request and byte of the currently granted channel.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (r_grant == 4'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      req_ready[i] = ce && w_slot_free && (r_state == S_DATA) && (r_grant == 4'(i));
    end
  end

  // Round-robin pick: scan rr_ptr+1, rr_ptr+2, ... with wrap at CHANNELS.
  // Offset k is the outer loop so the nearest requester after rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!w_found && req_valid[i] &&
            ((32'(r_rr_ptr) + k == i) || (32'(r_rr_ptr) + k == i + CHANNELS))) begin
          w_found = 1'b1;
          w_win   = 4'(i);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_cnt;
    if (ce) begin
      case (r_state)
        S_IDLE: begin
          if (w_slot_free && w_found) begin
            w_grant_nxt = w_win;
            w_rr_nxt    = w_win;
            w_cnt_nxt   = '0;
            w_state_nxt = S_DATA;
`ifdef IURT_ARB_TAG_EN
            w_valid_nxt = 1'b1;
            w_data_nxt  = {HDR_NIBBLE, w_win};
`else
            w_valid_nxt = 1'b0;
`endif
          end else if (w_slot_free) begin
            w_valid_nxt = 1'b0;
          end
        end
        S_DATA: begin
          if (w_slot_free) begin
            if (w_sel_valid) begin
              // Transfer: req_ready of the granted channel is high here.
              w_data_nxt  = w_sel_data;
              w_valid_nxt = 1'b1;
              w_cnt_nxt   = r_cnt + 8'd1;
              if (r_cnt + 8'd1 == MAX_CNT) begin
                w_state_nxt = S_IDLE;
              end
            end else begin
              w_valid_nxt = 1'b0;
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_grant  <= '0;
      r_rr_ptr <= RR_INIT;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_valid  <= w_valid_nxt;
      r_data   <= w_data_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign data_up_valid = r_valid;
  assign data_up       = r_data;
  assign grant_id      = r_grant;

endmodule

// File: tb/tb_iurt_up_arbiter.sv
// Self-checking bench for iurt_up_arbiter (CHANNELS=4, MAX_BURST=8).
// Expectations follow whichever IURT_ARB_TAG_EN setting the build uses.
// Data bytes are encoded {0, channel[1:0], seq[4:0]} so they never look
// like a tag and each one names its source and position.
module tb_iurt_up_arbiter;

  localparam int unsigned CH = 4;
  localparam int unsigned MB = 8;
  localparam logic [3:0]  HN = 4'hA;
`ifdef IURT_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            ce;
  logic [CH-1:0]   req_valid;
  logic [8*CH-1:0] req_data;
  logic [CH-1:0]   req_ready;
  logic            data_up_ready;
  logic            data_up_valid;
  logic [7:0]      data_up;
  logic [3:0]      grant_id;

  iurt_up_arbiter #(
    .CHANNELS   (CH),
    .MAX_BURST  (MB),
    .HDR_NIBBLE (HN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ce            (ce),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .data_up_ready (data_up_ready),
    .data_up_valid (data_up_valid),
    .data_up       (data_up),
    .grant_id      (grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic       rst;
    logic       ce;
    logic [3:0] rv;
    logic [7:0] rd;
    logic       rdy;
    logic       chk;
    logic       ev;
    logic [7:0] ed;
    logic [3:0] err;
    logic [3:0] eg;
  } vec_t;

  vec_t tbl[$];

  function automatic void addv(input logic r, input logic c, input logic [3:0] rv,
                               input logic [7:0] rd, input logic rdy, input logic chk,
                               input logic ev, input logic [7:0] ed,
                               input logic [3:0] err, input logic [3:0] eg);
    vec_t v;
    v.rst = r; v.ce = c; v.rv = rv; v.rd = rd; v.rdy = rdy;
    v.chk = chk; v.ev = ev; v.ed = ed; v.err = err; v.eg = eg;
    tbl.push_back(v);
  endfunction

  // ---------------- source / host models ----------------
  int          seq[CH];
  int          plan[CH];
  logic [CH-1:0] want;
  bit          rand_mode;
  logic [7:0]  host_q[$];
  logic [7:0]  exp_q[$];
  int          exp_seq[CH];
  int          cur_ch;
  int          burst_n;
  bit          stall_prev;
  logic [7:0]  stall_d;

  task automatic drive_src();
    for (int i = 0; i < int'(CH); i++) begin
      req_valid[i]       = want[i] && (seq[i] < plan[i]);
      req_data[8*i +: 8] = {1'b0, 2'(i), 5'(seq[i])};
    end
  endtask

  // Reference for the randomized run: per channel the host must see that
  // channel's bytes in generation order; with tags, each data byte belongs
  // to the last tagged channel and a burst holds at most MB bytes.
  task automatic model_byte(input logic [7:0] b);
    int ch;
    if (TAG_EN && b[7:4] == HN) begin
      check("rand.tag_range", 32'(b[3:0] < 4'(CH)), 1);
      cur_ch  = int'(b[3:0]);
      burst_n = 0;
    end else begin
      ch = int'(b[6:5]);
      check("rand.data", b, {1'b0, 2'(ch), 5'(exp_seq[ch])});
      exp_seq[ch]++;
      if (TAG_EN) begin
        check("rand.chan", ch, cur_ch);
        check("rand.burst_len", 32'(burst_n < int'(MB)), 1);
        burst_n++;
      end
    end
  endtask

  // One clock: observe handshakes at negedge, advance sources after posedge.
  task automatic step();
    logic [CH-1:0] xfer;
    @(negedge clk);
    xfer = req_valid & req_ready;
    if (stall_prev) begin
      check("stall.valid", data_up_valid, 1);
      check("stall.data", data_up, stall_d);
    end
    stall_prev = data_up_valid && !data_up_ready && !rst;
    stall_d    = data_up;
    if (data_up_valid && data_up_ready && ce && !rst) begin
      if (rand_mode) model_byte(data_up);
      else           host_q.push_back(data_up);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(CH); i++) if (xfer[i]) seq[i]++;
    drive_src();
  endtask

  task automatic phase_reset();
    want = '0; ce = 1'b1; data_up_ready = 1'b1;
    for (int i = 0; i < int'(CH); i++) begin seq[i] = 0; plan[i] = 0; end
    stall_prev = 1'b0;
    drive_src();
    rst = 1'b1;
    step();
    rst = 1'b0;
    host_q.delete();
  endtask

  task automatic check_host(input string name);
    check({name, ".len"}, host_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < host_q.size()) check($sformatf("%s[%0d]", name, i), host_q[i], exp_q[i]);
    end
  endtask

  initial begin
    bit done;
    rst = 1'b1; ce = 1'b1; req_valid = '0; req_data = '0; data_up_ready = 1'b1;
    want = '0; rand_mode = 1'b0; cur_ch = 15; burst_n = 0; stall_prev = 1'b0; stall_d = '0;
    for (int i = 0; i < int'(CH); i++) begin seq[i] = 0; plan[i] = 0; exp_seq[i] = 0; end

    //    rst  ce  rv       rd     rdy  chk  ev      ed                       req_ready  grant
    addv(1, 1, 4'b0000, 8'h00, 1, 0, 0,      8'h00,                    4'b0000, 4'd0);
    addv(0, 1, 4'b0000, 8'h00, 1, 1, 0,      8'h00,                    4'b0000, 4'd0);
    addv(0, 1, 4'b0010, 8'h11, 1, 1, 0,      8'h00,                    4'b0000, 4'd0);
    addv(0, 1, 4'b0010, 8'h11, 1, 1, TAG_EN, TAG_EN ? 8'hA1 : 8'h00,   4'b0010, 4'd1);
    addv(0, 0, 4'b0010, 8'h22, 1, 1, 1,      8'h11,                    4'b0000, 4'd1);
    addv(0, 0, 4'b0010, 8'h22, 1, 1, 1,      8'h11,                    4'b0000, 4'd1);
    addv(0, 1, 4'b0010, 8'h22, 1, 1, 1,      8'h11,                    4'b0010, 4'd1);
    addv(0, 1, 4'b0010, 8'h33, 0, 1, 1,      8'h22,                    4'b0000, 4'd1);
    addv(0, 1, 4'b0010, 8'h33, 0, 1, 1,      8'h22,                    4'b0000, 4'd1);
    addv(0, 1, 4'b0010, 8'h33, 1, 1, 1,      8'h22,                    4'b0010, 4'd1);
    addv(0, 1, 4'b0000, 8'h00, 1, 1, 1,      8'h33,                    4'b0010, 4'd1);
    addv(0, 1, 4'b0000, 8'h00, 1, 1, 0,      8'h33,                    4'b0000, 4'd1);
    addv(0, 1, 4'b0010, 8'h44, 1, 1, 0,      8'h33,                    4'b0000, 4'd1);
    addv(0, 1, 4'b0010, 8'h44, 1, 1, TAG_EN, TAG_EN ? 8'hA1 : 8'h33,   4'b0010, 4'd1);
    addv(1, 1, 4'b0010, 8'h55, 1, 1, 1,      8'h44,                    4'b0010, 4'd1);
    addv(0, 1, 4'b0000, 8'h00, 1, 1, 0,      8'h00,                    4'b0000, 4'd0);
    addv(0, 1, 4'b1111, 8'h66, 1, 1, 0,      8'h00,                    4'b0000, 4'd0);
    addv(0, 1, 4'b0000, 8'h00, 1, 1, TAG_EN, TAG_EN ? 8'hA0 : 8'h00,   4'b0001, 4'd0);
    addv(0, 1, 4'b0000, 8'h00, 1, 1, 0,      TAG_EN ? 8'hA0 : 8'h00,   4'b0000, 4'd0);

    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst; ce = tbl[k].ce; req_valid = tbl[k].rv;
      req_data = {CH{tbl[k].rd}}; data_up_ready = tbl[k].rdy;
      @(negedge clk);
      if (tbl[k].chk) begin
        check($sformatf("tbl%0d.valid", k), data_up_valid, tbl[k].ev);
        check($sformatf("tbl%0d.data", k), data_up, tbl[k].ed);
        check($sformatf("tbl%0d.req_ready", k), req_ready, tbl[k].err);
        check($sformatf("tbl%0d.grant", k), grant_id, tbl[k].eg);
      end
      @(posedge clk);
      #1;
    end

    // Idle after reset: nothing offered, nothing asserted.
    phase_reset();
    for (int c = 0; c < 20; c++) begin
      step();
      if (c % 5 == 0) begin
        check("idle.valid", data_up_valid, 0);
        check("idle.req_ready", req_ready, 0);
      end
    end

    // Two continuous requesters: round-robin bursts of exactly MB bytes.
    phase_reset();
    plan[0] = 16; plan[2] = 8; want = 4'b0101;
    drive_src();
    for (int c = 0; c < 45; c++) step();
    exp_q.delete();
    if (TAG_EN) exp_q.push_back(8'hA0);
    for (int j = 0; j < 8; j++) exp_q.push_back(8'(j));
    if (TAG_EN) exp_q.push_back(8'hA2);
    for (int j = 0; j < 8; j++) exp_q.push_back(8'h40 + 8'(j));
    if (TAG_EN) exp_q.push_back(8'hA0);
    for (int j = 8; j < 16; j++) exp_q.push_back(8'(j));
    check_host("rr");

    // Lone requester under host back-pressure (ready 1,0,0,...).
    phase_reset();
    plan[3] = 12; want = 4'b1000;
    drive_src();
    for (int c = 0; c < 75; c++) begin
      data_up_ready = (c % 3 == 0);
      step();
    end
    exp_q.delete();
    if (TAG_EN) exp_q.push_back(8'hA3);
    for (int j = 0; j < 8; j++) exp_q.push_back(8'h60 + 8'(j));
    if (TAG_EN) exp_q.push_back(8'hA3);
    for (int j = 8; j < 12; j++) exp_q.push_back(8'h60 + 8'(j));
    check_host("stall");
    check("stall.grant", grant_id, 3);

    // Randomized traffic, drops, stalls and ce gaps against the stream model.
    phase_reset();
    rand_mode = 1'b1; cur_ch = 15; burst_n = 0;
    for (int i = 0; i < int'(CH); i++) begin
      plan[i] = int'($urandom_range(20, 50));
      exp_seq[i] = 0;
    end
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      data_up_ready = ($urandom_range(0, 3) != 0);
      ce            = ($urandom_range(0, 7) != 0);
      want          = 4'($urandom);
      drive_src();
      step();
      done = 1'b1;
      for (int i = 0; i < int'(CH); i++) if (exp_seq[i] != plan[i]) done = 1'b0;
    end
    rand_mode = 1'b0;
    for (int i = 0; i < int'(CH); i++) begin
      check($sformatf("rand.drained%0d", i), exp_seq[i], plan[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
